// File: rtl/mips_pkg.sv
// Shared MIPS-side constants: datapath width, opcodes, loader commands and
// the loader FSM state encodings.
package mips_pkg;

    localparam int unsigned DATA_WIDTH = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [DATA_WIDTH-1:0] HALT_INSTR = 32'hFC00_0000;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_STEP = 8'h53;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_STEP = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/byte_packer.sv
// Packs incoming bytes little-endian into 32-bit words; word_done pulses
// for one cycle, the cycle after the fourth byte, with word holding the result.
module byte_packer
    import mips_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_in,
    output logic [DATA_WIDTH-1:0] word,
    output logic                  word_done
);

    logic [1:0]            idx_q;
    logic [DATA_WIDTH-1:0] shreg_q;
    logic [DATA_WIDTH-1:0] word_q;
    logic                  done_q;
    logic [DATA_WIDTH-1:0] shifted;

    // New byte enters at the top; after four shifts the first byte sits in [7:0].
    assign shifted = {byte_in, shreg_q[DATA_WIDTH-1:8]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q   <= '0;
            shreg_q <= '0;
            word_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (clear) begin
                idx_q <= '0;
            end else if (byte_valid) begin
                shreg_q <= shifted;
                idx_q   <= idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    word_q <= shifted;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign word      = word_q;
    assign word_done = done_q;

endmodule

// File: rtl/instr_loader.sv
// UART-driven program loader and run controller: writes received words into
// instruction memory, then runs or single-steps the core until it halts.
module instr_loader
    import mips_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 256,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    input  logic                  halt,
    output logic                  imem_we,
    output logic [DATA_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_wdata,
    output logic                  cpu_reset,
    output logic                  cpu_en,
    output logic                  load_err,
    output logic [CNT_WIDTH-1:0]  run_cycles,
    output logic [2:0]            state_o
);

    localparam int unsigned WIDX_W = $clog2(IMEM_DEPTH) + 1;
    localparam logic [WIDX_W-1:0] DEPTH_IDX = WIDX_W'(IMEM_DEPTH);

    state_t                state_q, state_d;
    logic [WIDX_W-1:0]     word_idx_q;
    logic                  load_err_q;
    logic [CNT_WIDTH-1:0]  run_cycles_q;
    logic                  step_q, step_d;
    logic                  restart_q, restart_d;
    logic                  restart_run_q, restart_run_d;

    logic                  clear_load;
    logic                  clear_cnt;
    logic                  we_c;
    logic                  set_err;
    logic                  en_c;
    logic                  rst_c;

    logic [DATA_WIDTH-1:0] word;
    logic                  word_done;
    logic                  pack_valid;

    assign pack_valid = rx_valid && (state_q == ST_LOAD);

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear_load),
        .byte_valid (pack_valid),
        .byte_in    (rx_data),
        .word       (word),
        .word_done  (word_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            word_idx_q    <= '0;
            load_err_q    <= 1'b0;
            run_cycles_q  <= '0;
            step_q        <= 1'b0;
            restart_q     <= 1'b0;
            restart_run_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            step_q        <= step_d;
            restart_q     <= restart_d;
            restart_run_q <= restart_run_d;
            if (clear_load) begin
                word_idx_q <= '0;
                load_err_q <= 1'b0;
            end else begin
                if (we_c)
                    word_idx_q <= word_idx_q + WIDX_W'(1);
                if (set_err)
                    load_err_q <= 1'b1;
            end
            if (clear_cnt)
                run_cycles_q <= '0;
            else if (en_c && (run_cycles_q != '1))
                run_cycles_q <= run_cycles_q + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        state_d       = state_q;
        step_d        = 1'b0;
        restart_d     = 1'b0;
        restart_run_d = restart_run_q;
        clear_load    = 1'b0;
        clear_cnt     = 1'b0;
        we_c          = 1'b0;
        set_err       = 1'b0;
        en_c          = 1'b0;
        rst_c         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                rst_c = 1'b1;
                if (rx_valid) begin
                    case (rx_data)
                        CMD_LOAD: begin state_d = ST_LOAD; clear_load = 1'b1; end
                        CMD_RUN:  begin state_d = ST_RUN;  clear_cnt  = 1'b1; end
                        CMD_STEP: begin state_d = ST_STEP; clear_cnt  = 1'b1; end
                        default:  ;
                    endcase
                end
            end
            ST_LOAD: begin
                rst_c = 1'b1;
                if (word_done) begin
                    if (word_idx_q == DEPTH_IDX) begin
                        set_err = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        we_c = 1'b1;
                        if (word == HALT_INSTR)
                            state_d = ST_IDLE;
                    end
                end
            end
            ST_RUN: begin
                if (halt)
                    state_d = ST_DONE;
                else
                    en_c = 1'b1;
            end
            ST_STEP: begin
                if (halt) begin
                    state_d = ST_DONE;
                end else begin
                    en_c = step_q;
                    if (rx_valid && rx_data == CMD_STEP)
                        step_d = 1'b1;
                    else if (rx_valid && rx_data == CMD_RUN)
                        state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                // Restart holds DONE one extra cycle so the core sees a reset pulse.
                if (restart_q) begin
                    rst_c     = 1'b1;
                    clear_cnt = 1'b1;
                    state_d   = restart_run_q ? ST_RUN : ST_STEP;
                end else if (rx_valid) begin
                    case (rx_data)
                        CMD_LOAD: begin state_d = ST_LOAD; clear_load = 1'b1; end
                        CMD_RUN:  begin restart_d = 1'b1; restart_run_d = 1'b1; end
                        CMD_STEP: begin restart_d = 1'b1; restart_run_d = 1'b0; end
                        default:  ;
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign imem_we    = we_c;
    assign imem_addr  = DATA_WIDTH'({word_idx_q, 2'b00});
    assign imem_wdata = word;
    assign cpu_reset  = rst_c;
    assign cpu_en     = en_c;
    assign load_err   = load_err_q;
    assign run_cycles = run_cycles_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: default instance plus IMEM_DEPTH=4 and
// CNT_WIDTH=4 instances, all driven by the same stimulus.
module tb_instr_loader;
    import mips_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, rx_valid, halt;
    logic [7:0] rx_data;

    logic        we_a, we_b, we_c;
    logic [31:0] addr_a, addr_b, addr_c, wdata_a, wdata_b, wdata_c;
    logic        crst_a, crst_b, crst_c, en_a, en_b, en_c;
    logic        err_a, err_b, err_c;
    logic [31:0] rc_a, rc_b;
    logic [3:0]  rc_c;
    logic [2:0]  st_a, st_b, st_c;

    instr_loader dut_a (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .halt(halt),
        .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wdata_a), .cpu_reset(crst_a),
        .cpu_en(en_a), .load_err(err_a), .run_cycles(rc_a), .state_o(st_a));

    instr_loader #(.IMEM_DEPTH(4)) dut_b (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .halt(halt),
        .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wdata_b), .cpu_reset(crst_b),
        .cpu_en(en_b), .load_err(err_b), .run_cycles(rc_b), .state_o(st_b));

    instr_loader #(.CNT_WIDTH(4)) dut_c (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .halt(halt),
        .imem_we(we_c), .imem_addr(addr_c), .imem_wdata(wdata_c), .cpu_reset(crst_c),
        .cpu_en(en_c), .load_err(err_c), .run_cycles(rc_c), .state_o(st_c));

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [31:0] wa_addr [8];
    logic [31:0] wa_data [8];
    logic [31:0] wb_addr [8];
    logic [31:0] wb_data [8];
    int unsigned wa_cnt, wb_cnt, ena_cnt, enc_cnt;

    // Sample mid-cycle, then move to just after the next rising edge.
    task automatic cycle();
        @(negedge clk);
        if (we_a) begin
            if (wa_cnt < 8) begin wa_addr[wa_cnt] = addr_a; wa_data[wa_cnt] = wdata_a; end
            wa_cnt++;
        end
        if (we_b) begin
            if (wb_cnt < 8) begin wb_addr[wb_cnt] = addr_b; wb_data[wb_cnt] = wdata_b; end
            wb_cnt++;
        end
        if (en_a) ena_cnt++;
        if (en_c) enc_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wa_cnt = 0; wb_cnt = 0; ena_cnt = 0; enc_cnt = 0;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) cycle();
    endtask

    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        rx_data = b; rx_valid = 1'b1;
        cycle();
        rx_valid = 1'b0;
        idle(gap);
    endtask

    task automatic send_word(input logic [31:0] w, input int unsigned gap);
        logic [31:0] t;
        t = w;
        for (int unsigned i = 0; i < 4; i++) send_byte(t[8*i +: 8], gap);
    endtask

    task automatic do_reset();
        reset = 1'b1; rx_valid = 1'b0; halt = 1'b0;
        idle(2);
        reset = 1'b0;
        idle(1);
        clear_logs();
    endtask

    task automatic test_reset();
        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; halt = 1'b0;
        idle(2);
        checks++; if (st_a !== 3'd0 || st_b !== 3'd0 || st_c !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d/%0d/%0d expected 0", st_a, st_b, st_c); end
        checks++; if ({we_a, we_b, we_c} !== 3'b000) begin errors++; $display("FAIL reset_we: got %b expected 000", {we_a, we_b, we_c}); end
        checks++; if ({addr_a, addr_b, addr_c, wdata_a, wdata_b, wdata_c} !== '0) begin errors++; $display("FAIL reset_addr_data: got %h %h %h %h %h %h expected 0", addr_a, addr_b, addr_c, wdata_a, wdata_b, wdata_c); end
        checks++; if ({crst_a, crst_b, crst_c} !== 3'b111) begin errors++; $display("FAIL reset_cpu_reset: got %b expected 111", {crst_a, crst_b, crst_c}); end
        checks++; if ({en_a, en_b, en_c, err_a, err_b, err_c} !== 6'b0) begin errors++; $display("FAIL reset_en_err: got %b expected 000000", {en_a, en_b, en_c, err_a, err_b, err_c}); end
        checks++; if (rc_a !== 32'd0 || rc_b !== 32'd0 || rc_c !== 4'd0) begin errors++; $display("FAIL reset_run_cycles: got %0d/%0d/%0d expected 0", rc_a, rc_b, rc_c); end
        reset = 1'b0;
        idle(1);
        // Halt and unknown bytes must leave IDLE untouched.
        halt = 1'b1;
        idle(3);
        send_byte(8'h00, 1);
        send_byte(8'h41, 1);
        halt = 1'b0;
        idle(1);
        checks++; if (st_a !== 3'd0 || en_a !== 1'b0 || crst_a !== 1'b1) begin errors++; $display("FAIL idle_ignores: got state %0d en %b rst %b expected 0 0 1", st_a, en_a, crst_a); end
    endtask

    task automatic test_load_halt();
        do_reset();
        send_byte(CMD_LOAD, 2);
        checks++; if (st_a !== 3'd1 || crst_a !== 1'b1) begin errors++; $display("FAIL load_enter: got state %0d rst %b expected 1 1", st_a, crst_a); end
        send_word(32'h2022_0001, 2);
        send_word(32'hFC00_0000, 2);
        idle(3);
        checks++; if (wa_cnt !== 2) begin errors++; $display("FAIL load_halt_count: got %0d expected 2", wa_cnt); end
        checks++; if (wa_addr[0] !== 32'h0 || wa_data[0] !== 32'h2022_0001) begin errors++; $display("FAIL load_halt_w0: got %h:%h expected 00000000:20220001", wa_addr[0], wa_data[0]); end
        checks++; if (wa_addr[1] !== 32'h4 || wa_data[1] !== 32'hFC00_0000) begin errors++; $display("FAIL load_halt_w1: got %h:%h expected 00000004:fc000000", wa_addr[1], wa_data[1]); end
        checks++; if (st_a !== 3'd0 || crst_a !== 1'b1 || err_a !== 1'b0) begin errors++; $display("FAIL load_halt_end: got state %0d rst %b err %b expected 0 1 0", st_a, crst_a, err_a); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        do_reset();
        send_byte(CMD_LOAD, 0);
        for (int unsigned i = 0; i < 5; i++) begin
            w = 32'h2042_0000 + i;
            send_word(w, 0);
        end
        idle(3);
        checks++; if (wb_cnt !== 4) begin errors++; $display("FAIL ovf_count: got %0d expected 4", wb_cnt); end
        for (int unsigned i = 0; i < 4; i++) begin
            checks++; if (wb_addr[i] !== 32'(4 * i) || wb_data[i] !== 32'h2042_0000 + i) begin errors++; $display("FAIL ovf_write%0d: got %h:%h expected %h:%h", i, wb_addr[i], wb_data[i], 32'(4 * i), 32'h2042_0000 + i); end
        end
        checks++; if (err_b !== 1'b1 || st_b !== 3'd0) begin errors++; $display("FAIL ovf_err: got err %b state %0d expected 1 0", err_b, st_b); end
        checks++; if (wa_cnt !== 5 || wa_addr[4] !== 32'h10 || wa_data[4] !== 32'h2042_0004) begin errors++; $display("FAIL b2b_deep: got %0d writes last %h:%h expected 5 00000010:20420004", wa_cnt, wa_addr[4], wa_data[4]); end
        checks++; if (err_a !== 1'b0 || st_a !== 3'd1) begin errors++; $display("FAIL b2b_deep_state: got err %b state %0d expected 0 1", err_a, st_a); end
    endtask

    task automatic test_reset_midword();
        do_reset();
        send_byte(CMD_LOAD, 1);
        send_byte(8'hAA, 1);
        send_byte(8'hBB, 1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        idle(1);
        send_byte(CMD_LOAD, 1);
        send_word(32'h4433_2211, 1);
        idle(2);
        checks++; if (wa_cnt !== 1 || wa_addr[0] !== 32'h0 || wa_data[0] !== 32'h4433_2211) begin errors++; $display("FAIL midword_reset: got %0d writes %h:%h expected 1 00000000:44332211", wa_cnt, wa_addr[0], wa_data[0]); end
    endtask

    task automatic test_run();
        do_reset();
        send_byte(CMD_RUN, 0);
        checks++; if (st_a !== 3'd2 || crst_a !== 1'b0 || en_a !== 1'b1) begin errors++; $display("FAIL run_enter: got state %0d rst %b en %b expected 2 0 1", st_a, crst_a, en_a); end
        idle(37);
        halt = 1'b1;
        cycle();
        halt = 1'b0;
        idle(3);
        checks++; if (ena_cnt !== 37) begin errors++; $display("FAIL run_en_cycles: got %0d expected 37", ena_cnt); end
        checks++; if (rc_a !== 32'd37 || st_a !== 3'd4 || en_a !== 1'b0) begin errors++; $display("FAIL run_done: got cycles %0d state %0d en %b expected 37 4 0", rc_a, st_a, en_a); end
        checks++; if (rc_c !== 4'd15 || enc_cnt !== 37) begin errors++; $display("FAIL run_saturate37: got %0d (en %0d) expected 15 (37)", rc_c, enc_cnt); end
    endtask

    task automatic test_saturate();
        do_reset();
        send_byte(CMD_RUN, 0);
        idle(20);
        halt = 1'b1;
        cycle();
        halt = 1'b0;
        idle(2);
        checks++; if (rc_c !== 4'd15 || st_c !== 3'd4) begin errors++; $display("FAIL saturate: got %0d state %0d expected 15 4", rc_c, st_c); end
        checks++; if (rc_a !== 32'd20) begin errors++; $display("FAIL saturate_wide: got %0d expected 20", rc_a); end
    endtask

    task automatic test_step_restart();
        do_reset();
        send_byte(CMD_STEP, 9);
        send_byte(CMD_STEP, 9);
        send_byte(CMD_STEP, 9);
        checks++; if (ena_cnt !== 2 || rc_a !== 32'd2) begin errors++; $display("FAIL step_pulses: got %0d pulses count %0d expected 2 2", ena_cnt, rc_a); end
        checks++; if (st_a !== 3'd3 || crst_a !== 1'b0) begin errors++; $display("FAIL step_state: got %0d rst %b expected 3 0", st_a, crst_a); end
        halt = 1'b1;
        cycle();
        halt = 1'b0;
        idle(2);
        checks++; if (st_a !== 3'd4 || rc_a !== 32'd2) begin errors++; $display("FAIL step_halt: got state %0d count %0d expected 4 2", st_a, rc_a); end
        send_byte(CMD_RUN, 0);
        checks++; if (crst_a !== 1'b1 || st_a !== 3'd4 || en_a !== 1'b0) begin errors++; $display("FAIL restart_pulse: got rst %b state %0d en %b expected 1 4 0", crst_a, st_a, en_a); end
        cycle();
        checks++; if (crst_a !== 1'b0 || st_a !== 3'd2 || rc_a !== 32'd0 || en_a !== 1'b1) begin errors++; $display("FAIL restart_run: got rst %b state %0d count %0d en %b expected 0 2 0 1", crst_a, st_a, rc_a, en_a); end
        cycle();
        halt = 1'b1;
        cycle();
        halt = 1'b0;
        idle(1);
        checks++; if (st_a !== 3'd4 || rc_a !== 32'd1) begin errors++; $display("FAIL restart_done: got state %0d count %0d expected 4 1", st_a, rc_a); end
    endtask

    initial begin
        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; halt = 1'b0;
        clear_logs();
        test_reset();
        test_load_halt();
        test_back_to_back();
        test_reset_midword();
        test_run();
        test_saturate();
        test_step_restart();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
